sccpu_debug_ctrl: RTL and testbench

- Run-control sequencer for the single-cycle CPU datapath (sccpu_dataflow).
- Gates the CPU with a clock enable and drives its reset.
- Implements run / halt / single-step / N-step, one PC breakpoint and one store-address watchpoint.
- Accepts commands from a testbench or host over a valid/ready handshake, and reports state, halt cause and retired-instruction count.

---
 rtl/sccpu_dbg_pkg.sv | 34 +++
 rtl/sccpu_debug_ctrl_if.sv | 12 +
 rtl/sccpu_dbg_match.sv | 63 ++++++
 rtl/sccpu_debug_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sccpu_debug_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/sccpu_dbg_pkg.sv
// Shared encodings for the sccpu run-control sequencer.
// Holds the run-control state encoding, the command opcodes carried on
// cmd_op, the halt-cause encoding and the default CPU reset length.
package sccpu_dbg_pkg;

    localparam int unsigned DEF_RST_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_CPURST = 2'd3
    } dbg_state_e;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_RUN       = 3'd1,
        OP_HALT      = 3'd2,
        OP_STEP      = 3'd3,
        OP_SET_BP    = 3'd4,
        OP_CLR_BP    = 3'd5,
        OP_RESET_CPU = 3'd6,
        OP_SET_WP    = 3'd7
    } dbg_op_e;

    typedef enum logic [2:0] {
        HC_RESET     = 3'd0,
        HC_CMD       = 3'd1,
        HC_STEP_DONE = 3'd2,
        HC_BP        = 3'd3,
        HC_WP        = 3'd4
    } halt_cause_e;

endpackage

// File: rtl/sccpu_debug_ctrl_if.sv
// Command channel of the run-control sequencer.
// master: host side (drives cmd_valid/cmd_op/cmd_arg, sees cmd_ready).
// slave : sequencer side (accepts a command when cmd_valid && cmd_ready).
interface sccpu_debug_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_arg;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/sccpu_dbg_match.sv
// Breakpoint / watchpoint address storage and comparators.
// Ports: clock, resetn (sync, active-high); set_bp/clr_bp/set_wp load or
// clear the registers from addr; pc and wmem/alu_out are the CPU's current
// fetch address and store request; bp_match/wp_match are the raw compares
// (skip and cpu_en qualification is applied by the sequencer).
module sccpu_dbg_match (
    input  logic        clock,
    input  logic        resetn,
    input  logic        set_bp,
    input  logic        clr_bp,
    input  logic        set_wp,
    input  logic [31:0] addr,
    input  logic [31:0] pc,
    input  logic        wmem,
    input  logic [31:0] alu_out,
    output logic        bp_match,
    output logic        wp_match
);
    logic        bp_valid_q, bp_valid_d;
    logic [31:0] bp_addr_q,  bp_addr_d;
    logic        wp_valid_q, wp_valid_d;
    logic [31:0] wp_addr_q,  wp_addr_d;

    // Next-value logic for the address/valid registers.
    always_comb begin
        bp_valid_d = bp_valid_q;
        bp_addr_d  = bp_addr_q;
        wp_valid_d = wp_valid_q;
        wp_addr_d  = wp_addr_q;
        if (set_bp) begin
            bp_valid_d = 1'b1;
            bp_addr_d  = addr;
        end else if (clr_bp) begin
            bp_valid_d = 1'b0;
        end else begin
            bp_valid_d = bp_valid_q;
        end
        if (set_wp) begin
            wp_valid_d = 1'b1;
            wp_addr_d  = addr;
        end else begin
            wp_valid_d = wp_valid_q;
        end
    end

    // Register storage; only resetn clears the match units.
    always_ff @(posedge clock) begin
        if (resetn) begin
            bp_valid_q <= 1'b0;
            bp_addr_q  <= 32'h0000_0000;
            wp_valid_q <= 1'b0;
            wp_addr_q  <= 32'h0000_0000;
        end else begin
            bp_valid_q <= bp_valid_d;
            bp_addr_q  <= bp_addr_d;
            wp_valid_q <= wp_valid_d;
            wp_addr_q  <= wp_addr_d;
        end
    end

    assign bp_match = bp_valid_q && (pc == bp_addr_q);
    assign wp_match = wp_valid_q && wmem && (alu_out == wp_addr_q);
endmodule

// File: rtl/sccpu_debug_ctrl.sv
// Run-control sequencer for the single-cycle CPU.
// Ports: clock, resetn (sync, active-high); cmd (command handshake, slave);
// pc/wmem/alu_out observe the CPU; cpu_en/cpu_rst gate and reset it;
// state/halt_cause/retired report status; cmd_err pulses one cycle after
// an accepted command that is illegal in the current state.
module sccpu_debug_ctrl
    import sccpu_dbg_pkg::*;
#(
    parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
    parameter int unsigned CNT_W      = 32
) (
    input  logic               clock,
    input  logic               resetn,
    sccpu_debug_ctrl_if.slave  cmd,
    input  logic [31:0]        pc,
    input  logic               wmem,
    input  logic [31:0]        alu_out,
    output logic               cpu_en,
    output logic               cpu_rst,
    output logic [1:0]         state,
    output logic [2:0]         halt_cause,
    output logic               cmd_err,
    output logic [CNT_W-1:0]   retired
);
    dbg_state_e  state_q, state_d;
    halt_cause_e cause_q, cause_d;
    logic [31:0]      rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             bp_skip_q, bp_skip_d;
    logic             cmd_err_q, cmd_err_d;

    dbg_op_e          op_s;
    logic             accept_s, active_s, bp_match_s, wp_match_s;
    logic             bp_hit_s, wp_hit_s, step_last_s;
    logic [CNT_W-1:0] step_arg_s;

    assign op_s          = dbg_op_e'(cmd.cmd_op);
    assign cmd.cmd_ready = (state_q != ST_CPURST);
    assign accept_s      = cmd.cmd_valid && cmd.cmd_ready;
    assign active_s      = (state_q == ST_RUN) || (state_q == ST_STEP);
    // The skip flag lets a resumed CPU execute the breakpointed instruction once.
    assign bp_hit_s      = active_s && bp_match_s && !bp_skip_q;
    assign cpu_en        = active_s && !bp_hit_s;
    assign wp_hit_s      = cpu_en && wp_match_s;
    assign step_last_s   = (state_q == ST_STEP) && cpu_en && (step_cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});
    assign step_arg_s    = cmd.cmd_arg[CNT_W-1:0];

    sccpu_dbg_match u_match (
        .clock    (clock),
        .resetn   (resetn),
        .set_bp   (accept_s && (op_s == OP_SET_BP)),
        .clr_bp   (accept_s && (op_s == OP_CLR_BP)),
        .set_wp   (accept_s && (op_s == OP_SET_WP)),
        .addr     (cmd.cmd_arg),
        .pc       (pc),
        .wmem     (wmem),
        .alu_out  (alu_out),
        .bp_match (bp_match_s),
        .wp_match (wp_match_s)
    );

    // Next-state, counter and halt-cause logic.
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        rst_cnt_d  = rst_cnt_q;
        step_cnt_d = step_cnt_q;
        retired_d  = retired_q;
        bp_skip_d  = bp_skip_q;
        cmd_err_d  = 1'b0;

        if (cpu_en) begin
            retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
            bp_skip_d = 1'b0;
        end else begin
            retired_d = retired_q;
        end
        if (accept_s && (op_s == OP_SET_BP)) begin
            bp_skip_d = 1'b0;
        end else begin
            step_cnt_d = step_cnt_q;
        end

        case (state_q)
            ST_CPURST: begin
                if (rst_cnt_q == 32'd0) begin
                    state_d = ST_HALTED;
                end else begin
                    rst_cnt_d = rst_cnt_q - 32'd1;
                end
            end
            ST_HALTED: begin
                if (accept_s) begin
                    case (op_s)
                        OP_RUN:  state_d = ST_RUN;
                        OP_STEP: begin
                            state_d    = ST_STEP;
                            step_cnt_d = (step_arg_s == {CNT_W{1'b0}}) ? {{(CNT_W-1){1'b0}}, 1'b1} : step_arg_s;
                        end
                        OP_RESET_CPU: begin
                            state_d   = ST_CPURST;
                            cause_d   = HC_RESET;
                            retired_d = {CNT_W{1'b0}};
                            rst_cnt_d = 32'(RST_CYCLES - 1);
                        end
                        default: state_d = ST_HALTED;
                    endcase
                end else begin
                    state_d = ST_HALTED;
                end
            end
            ST_RUN, ST_STEP: begin
                if (accept_s && ((op_s == OP_RUN) || (op_s == OP_STEP) || (op_s == OP_RESET_CPU))) begin
                    cmd_err_d = 1'b1;
                end else begin
                    cmd_err_d = 1'b0;
                end
                if ((state_q == ST_STEP) && cpu_en) begin
                    step_cnt_d = step_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    step_cnt_d = step_cnt_q;
                end
                // Several halt sources may coincide; one transition, prioritised cause.
                if (bp_hit_s) begin
                    state_d   = ST_HALTED;
                    cause_d   = HC_BP;
                    bp_skip_d = 1'b1;
                end else if (wp_hit_s) begin
                    state_d = ST_HALTED;
                    cause_d = HC_WP;
                end else if (accept_s && (op_s == OP_HALT)) begin
                    state_d = ST_HALTED;
                    cause_d = HC_CMD;
                end else if (step_last_s) begin
                    state_d = ST_HALTED;
                    cause_d = HC_STEP_DONE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_CPURST;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clock) begin
        if (resetn) begin
            state_q    <= ST_CPURST;
            cause_q    <= HC_RESET;
            rst_cnt_q  <= 32'(RST_CYCLES - 1);
            step_cnt_q <= {CNT_W{1'b0}};
            retired_q  <= {CNT_W{1'b0}};
            bp_skip_q  <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            rst_cnt_q  <= rst_cnt_d;
            step_cnt_q <= step_cnt_d;
            retired_q  <= retired_d;
            bp_skip_q  <= bp_skip_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    assign cpu_rst    = (state_q == ST_CPURST);
    assign state      = state_q;
    assign halt_cause = cause_q;
    assign cmd_err    = cmd_err_q;
    assign retired    = retired_q;
endmodule

// File: tb/tb_sccpu_debug_ctrl.sv
// Bench for sccpu_debug_ctrl: directed scenarios followed by random commands,
// a toy CPU whose pc advances by 4 per retired instruction, and a scoreboard
// fed by a behavioural model of the run-control rules.
module tb_sccpu_debug_ctrl;
    localparam logic [2:0] NOP = 3'd0, RUN = 3'd1, HALT = 3'd2, STEP = 3'd3,
                           SBP = 3'd4, CBP = 3'd5, RCPU = 3'd6, SWP = 3'd7;
    localparam int RSTC = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] pc = 32'd0;
    logic        wmem = 1'b0;
    logic [31:0] alu_out = 32'd0;
    logic        cpu_en, cpu_rst, cmd_err;
    logic [1:0]  state;
    logic [2:0]  halt_cause;
    logic [31:0] retired;

    sccpu_debug_ctrl_if cmd_if();

    sccpu_debug_ctrl #(.RST_CYCLES(RSTC), .CNT_W(32)) dut (
        .clock(clock), .resetn(resetn), .cmd(cmd_if), .pc(pc), .wmem(wmem),
        .alu_out(alu_out), .cpu_en(cpu_en), .cpu_rst(cpu_rst), .state(state),
        .halt_cause(halt_cause), .cmd_err(cmd_err), .retired(retired)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  st;
        logic [2:0]  hc;
        logic [31:0] ret;
        logic        err;
        logic        rst;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad = 0;

    // Model: mode 0 halted, 1 running, 2 stepping, 3 CPU held in reset.
    int          m_mode = 3;
    int          m_rst_left = RSTC - 1;
    logic [31:0] m_steps = 0, m_retired = 0, m_bp = 0, m_wp = 0;
    int          m_cause = 0;
    bit          m_bp_on = 0, m_wp_on = 0, m_skip = 0, m_err = 0, m_known = 0;
    logic [31:0] cpu_pc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus plus the model's view of that cycle.
    task automatic tick(input bit r, input bit v, input logic [2:0] op, input logic [31:0] arg,
                        input bit wm, input logic [31:0] alu, input bit jump, input logic [31:0] jpc);
        bit act, bph, en, wph, acc, last;
        exp_t e;
        @(negedge clock);
        resetn = r; cmd_if.cmd_valid = v; cmd_if.cmd_op = op; cmd_if.cmd_arg = arg;
        pc = cpu_pc; wmem = wm; alu_out = alu;
        #1;
        act = (m_mode == 1) || (m_mode == 2);
        bph = act && m_bp_on && (cpu_pc == m_bp) && !m_skip;
        en  = act && !bph;
        wph = en && m_wp_on && wm && (alu == m_wp);
        acc = v && (m_mode != 3);
        if (m_known) begin
            chk("cpu_en", cpu_en, en);
            chk("cmd_ready", cmd_if.cmd_ready, m_mode != 3);
        end
        if (m_mode == 3) cpu_pc = 32'd0;
        else if (en) cpu_pc = jump ? jpc : cpu_pc + 32'd4;
        if (r) begin
            m_mode = 3; m_rst_left = RSTC - 1; m_retired = 0; m_cause = 0; m_err = 0;
            m_bp_on = 0; m_wp_on = 0; m_skip = 0; m_known = 1;
        end else begin
            m_err = 0;
            last = (m_mode == 2) && en && (m_steps == 32'd1);
            if (en) begin m_retired++; m_skip = 0; end
            if (m_mode == 2 && en) m_steps--;
            if (acc && op == SBP) begin m_bp = arg; m_bp_on = 1; m_skip = 0; end
            if (acc && op == CBP) m_bp_on = 0;
            if (acc && op == SWP) begin m_wp = arg; m_wp_on = 1; end
            if (m_mode == 3) begin
                if (m_rst_left == 0) m_mode = 0; else m_rst_left--;
            end else if (m_mode == 0) begin
                if (acc && op == RUN) m_mode = 1;
                if (acc && op == STEP) begin m_mode = 2; m_steps = (arg == 0) ? 32'd1 : arg; end
                if (acc && op == RCPU) begin m_mode = 3; m_rst_left = RSTC - 1; m_retired = 0; m_cause = 0; end
            end else begin
                if (acc && (op == RUN || op == STEP || op == RCPU)) m_err = 1;
                if (bph) begin m_mode = 0; m_cause = 3; m_skip = 1; end
                else if (wph) begin m_mode = 0; m_cause = 4; end
                else if (acc && op == HALT) begin m_mode = 0; m_cause = 1; end
                else if (last) begin m_mode = 0; m_cause = 2; end
            end
        end
        e.st = 2'(m_mode); e.hc = 3'(m_cause); e.ret = m_retired; e.err = m_err; e.rst = (m_mode == 3);
        sb.push_back(e);
        @(posedge clock);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, NOP, 0, 0, 32'h100, 0, 0);
    endtask

    task automatic cmd(input logic [2:0] op, input logic [31:0] arg);
        tick(0, 1, op, arg, 0, 32'h100, 0, 0);
    endtask

    // Monitor: compares the registered outputs after every clock edge.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("state", state, e.st);
            chk("halt_cause", halt_cause, e.hc);
            chk("retired", retired, e.ret);
            chk("cmd_err", cmd_err, e.err);
            chk("cpu_rst", cpu_rst, e.rst);
        end
    end

    initial begin
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 3'd0; cmd_if.cmd_arg = 32'd0;
        // Reset: cpu_rst held exactly 4 cycles.
        tick(1, 0, NOP, 0, 0, 0, 0, 0);
        idle(3);
        chk("rst_still_cpurst", state, 32'd3);
        idle(1);
        chk("rst_released", state, 32'd0);
        chk("rst_cause", halt_cause, 32'd0);
        // STEP 3 then STEP 0.
        cmd(STEP, 3); idle(6);
        chk("step3_retired", retired, 32'd3);
        chk("step3_cause", halt_cause, 32'd2);
        cmd(STEP, 0); idle(3);
        chk("step0_retired", retired, 32'd4);
        // Breakpoint at 0x10 and resume across it.
        cmd(RCPU, 0); idle(5);
        cmd(SBP, 32'h10); cmd(RUN, 0); idle(8);
        chk("bp_retired", retired, 32'd4);
        chk("bp_cause", halt_cause, 32'd3);
        chk("bp_pc", cpu_pc, 32'h10);
        cmd(STEP, 1); idle(3);
        chk("bp_resume_retired", retired, 32'd5);
        chk("bp_resume_cause", halt_cause, 32'd2);
        cmd(CBP, 0);
        // Watchpoint on the 6th retired store.
        cmd(RCPU, 0); idle(5);
        cmd(SWP, 32'h20); cmd(RUN, 0);
        for (int i = 0; i < 10; i++) begin
            if (m_retired == 5 && m_mode == 1) tick(0, 0, NOP, 0, 1, 32'h20, 0, 0);
            else tick(0, 0, NOP, 0, 1, 32'h24, 0, 0);
        end
        chk("wp_retired", retired, 32'd6);
        chk("wp_cause", halt_cause, 32'd4);
        // Illegal commands while running, then HALT.
        cmd(RUN, 0); cmd(RUN, 0); cmd(RCPU, 0); idle(1);
        chk("err_still_run", state, 32'd1);
        cmd(HALT, 0);
        chk("halt_cause_cmd", halt_cause, 32'd1);
        // HALT in the same cycle as a watchpoint store.
        cmd(RUN, 0); idle(2);
        tick(0, 1, HALT, 0, 1, 32'h20, 0, 0);
        chk("halt_wp_cause", halt_cause, 32'd4);
        // resetn mid-run clears the breakpoint.
        cmd(SBP, 32'h10); cmd(RUN, 0); idle(2);
        tick(1, 1, RUN, 0, 0, 0, 0, 0);
        chk("midrst_state", state, 32'd3);
        chk("midrst_retired", retired, 32'd0);
        idle(4); cmd(RUN, 0); idle(8);
        chk("bp_cleared_running", state, 32'd1);
        cmd(HALT, 0);
        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            bit          r, v, wm, jp;
            logic [2:0]  op;
            logic [31:0] arg;
            r  = ($urandom_range(0, 399) == 0);
            v  = ($urandom_range(0, 9) < 3);
            op = 3'($urandom_range(0, 7));
            if (op == RCPU && $urandom_range(0, 3) != 0) op = NOP;
            case (op)
                STEP:    arg = 32'($urandom_range(0, 5));
                SBP:     arg = 32'($urandom_range(0, 16) * 4);
                SWP:     arg = 32'($urandom_range(8, 10) * 4);
                default: arg = $urandom;
            endcase
            wm = ($urandom_range(0, 9) < 3);
            jp = ($urandom_range(0, 7) == 0);
            tick(r, v, op, arg, wm, 32'($urandom_range(8, 10) * 4), jp, 32'($urandom_range(0, 16) * 4));
        end
        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
